tdm_slot_sequencer: RTL
=======================

// Module: tdm_slot_sequencer
// PURPOSE
//  Upstream feeder for the 1-to-8 channel demultiplexer.
//  - Frames a serial TDM bitstream; each frame = 8-bit sync word + 8 payload slots of SLOT_BITS bits.
//  - Drives the demux select lines (s2,s1,s0) with the current slot index and its data input with the payload bit.
//  - Tracks frame lock with a flywheel, so one corrupted sync word does not drop the link.
// PARAMETERS
//  SYNC_WORD   8'hA5  frame alignment pattern, MSB received first
//  SLOT_BITS   4      payload bits per slot (legal 1..16)
//  MISS_LIMIT  3      consecutive bad sync words that force loss of lock (legal 1..15)
// PORTS
//  clk          in   1  rising-edge clock
//  rst_n        in   1  asynchronous active-low reset
//  rx_bit       in   1  serial data bit
//  rx_valid     in   1  rx_bit is valid this cycle; no state advances while low
//  s0           out  1  slot index bit 0, to demux
//  s1           out  1  slot index bit 1, to demux
//  s2           out  1  slot index bit 2, to demux
//  dout         out  1  payload bit, to demux data input
//  dout_valid   out  1  dout/select valid this cycle
//  locked       out  1  frame lock indicator
//  frame_start  out  1  one-cycle pulse: first payload bit of slot 0
//  sync_err     out  1  one-cycle pulse: sync word mismatch while locked
// BEHAVIOUR
//  Reset values (async assert, sync release)
//  - All outputs 0; state=HUNT; shift reg, bit/slot/miss counters = 0.
//  States (transitions only on cycles with rx_valid=1)
//  - HUNT:
//    - Shift rx_bit into 8-bit reg (LSB in).
//    - When {reg[6:0],rx_bit}==SYNC_WORD: go PAYLOAD, set locked=1, clear miss_cnt.
//  - PAYLOAD:
//    - Each valid bit: dout=rx_bit, dout_valid=1, {s2,s1,s0}=slot_cnt, all registered (1-cycle latency).
//    - bit_cnt counts 0..SLOT_BITS-1. At wrap, slot_cnt++.
//    - After last bit of slot 7: go CHECK with bit_cnt=0, slot_cnt=0.
//    - frame_start=1 with the output of slot 0 bit 0.
//  - CHECK:
//    - Collect 8 bits, comparing against SYNC_WORD.
//    - Match: miss_cnt=0 -> PAYLOAD.
//    - Mismatch: sync_err pulse on the cycle after the 8th bit; miss_cnt++.
//      - If miss_cnt reaches MISS_LIMIT: locked=0, clear counters and shift reg -> HUNT.
//      - Otherwise -> PAYLOAD (flywheel; locked stays 1).
//  Output rules
//  - dout_valid=0 and dout=0 on any cycle not outputting payload, including rx_valid=0 cycles.
//  - s2..s0 hold their last value when dout_valid=0.
//  - rx_valid=0 mid-slot/mid-sync: freeze all counters; resume exactly on next valid bit.
//  - Entering HUNT from CHECK discards the failed word; hunting restarts on next bit (no overlap reuse).
//  - Slot index is exactly 3 bits; slot_cnt never exceeds 7. bit_cnt width = $clog2(SLOT_BITS+1).
//  - rst_n low at any point: immediate return to reset values, including mid-frame.
// TESTING
//  1. Reset, then bits A5 + 32 payload bits (slot k = 4'hk) -> locked=1 one cycle after last sync bit.
//     Each slot k: {s2,s1,s0}=k, dout follows rx_bit with 1-cycle latency. frame_start once.
//  2. Noise 0x3C,0x5A then A5 -> no dout_valid before the A5 completes; lock on the A5 bit boundary.
//  3. Locked; one corrupted sync word 0xA4 -> sync_err pulse, locked stays 1.
//     Next frame payload still delivered; miss_cnt clears on next good A5.
//  4. Locked; 3 consecutive bad sync words -> 3 sync_err pulses.
//     locked=0 after the third; dout_valid stays 0 until a new A5.
//  5. rx_valid toggled 1010... across slot 3->4 boundary -> same sequence as test 1.
//     dout_valid only on cycles following valid bits.
//  6. Assert rst_n=0 mid slot 5 -> all outputs 0 asynchronously.
//     After release, HUNT: no payload until a new A5.

Source files
------------

// File: rtl/tdm_slot_sequencer.sv
// tdm_slot_sequencer: frames a serial TDM bitstream (sync word + 8 payload
// slots) and feeds the 1-to-8 demux with a slot index and the payload bit.
// A flywheel tolerates isolated bad sync words before dropping lock.
module tdm_slot_sequencer #(
  parameter logic [7:0] SYNC_WORD  = 8'hA5,
  parameter int         SLOT_BITS  = 4,
  parameter int         MISS_LIMIT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_bit,
  input  logic rx_valid,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic dout,
  output logic dout_valid,
  output logic locked,
  output logic frame_start,
  output logic sync_err
);

  localparam int               BW       = $clog2(SLOT_BITS + 1);
  localparam logic [BW-1:0]    LAST_BIT = BW'(SLOT_BITS - 1);
  localparam logic [3:0]       MISS_MAX = 4'(MISS_LIMIT);

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  state_t        state, state_d;
  logic [7:0]    shreg, shreg_d;
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic [2:0]    slot_cnt, slot_cnt_d;   // slot index in PAYLOAD, sync bit index in CHECK
  logic [3:0]    miss_cnt, miss_cnt_d;
  logic [2:0]    sel, sel_d;
  logic          dout_d, dout_valid_d, locked_d, frame_start_d, sync_err_d;
  logic [7:0]    word;

  // Candidate sync word including the bit arriving this cycle.
  assign word = {shreg[6:0], rx_bit};

  assign s0 = sel[0];
  assign s1 = sel[1];
  assign s2 = sel[2];

  // State and registered outputs; everything returns to zero on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HUNT;
      shreg       <= '0;
      bit_cnt     <= '0;
      slot_cnt    <= '0;
      miss_cnt    <= '0;
      sel         <= '0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // computed from the same clock edge, independent of statement order.
      state       <= state_d;
      shreg       <= shreg_d;
      bit_cnt     <= bit_cnt_d;
      slot_cnt    <= slot_cnt_d;
      miss_cnt    <= miss_cnt_d;
      sel         <= sel_d;
      dout        <= dout_d;
      dout_valid  <= dout_valid_d;
      locked      <= locked_d;
      frame_start <= frame_start_d;
      sync_err    <= sync_err_d;
    end
  end

  // Next-state and next-output logic; nothing advances without rx_valid.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d       = state;
    shreg_d       = shreg;
    bit_cnt_d     = bit_cnt;
    slot_cnt_d    = slot_cnt;
    miss_cnt_d    = miss_cnt;
    sel_d         = sel;          // select lines hold between payload bits
    dout_d        = 1'b0;
    dout_valid_d  = 1'b0;
    locked_d      = locked;
    frame_start_d = 1'b0;
    sync_err_d    = 1'b0;

    if (rx_valid) begin
      unique case (state)
        HUNT: begin
          shreg_d = word;
          if (word == SYNC_WORD) begin
            state_d    = PAYLOAD;
            locked_d   = 1'b1;
            miss_cnt_d = '0;
            bit_cnt_d  = '0;
            slot_cnt_d = '0;
          end
        end

        PAYLOAD: begin
          dout_d        = rx_bit;
          dout_valid_d  = 1'b1;
          sel_d         = slot_cnt;
          frame_start_d = (slot_cnt == 3'd0) && (bit_cnt == '0);
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_d  = '0;
            slot_cnt_d = slot_cnt + 3'd1;  // 7 wraps to 0, ready to count sync bits
            if (slot_cnt == 3'd7) begin
              state_d = CHECK;
            end
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
          end
        end

        CHECK: begin
          shreg_d    = word;
          slot_cnt_d = slot_cnt + 3'd1;
          if (slot_cnt == 3'd7) begin
            if (word == SYNC_WORD) begin
              miss_cnt_d = '0;
              state_d    = PAYLOAD;
            end else begin
              sync_err_d = 1'b1;
              if (miss_cnt + 4'd1 == MISS_MAX) begin
                // Lock lost: discard the failed word so hunting starts clean.
                locked_d   = 1'b0;
                miss_cnt_d = '0;
                bit_cnt_d  = '0;
                slot_cnt_d = '0;
                shreg_d    = '0;
                state_d    = HUNT;
              end else begin
                miss_cnt_d = miss_cnt + 4'd1;
                state_d    = PAYLOAD;
              end
            end
          end
        end

        default: begin
          state_d = HUNT;
        end
      endcase
    end
  end

endmodule
